uart_rx: RTL and testbench

Serial UART receiver that oversamples the `rx` line, deframes start/data/stop bits and delivers each received word as a one-cycle write strobe plus data. It sits directly upstream of the receive FIFO. `rx_done_tick` drives the FIFO `wr` input and `rx_data` drives its `w_data` input. An internal baud-tick generator makes the block self-contained; no other timing source is needed.

---
 rtl/uart_pkg.sv | 16 +
 rtl/baud_gen.sv | 30 +++
 rtl/uart_rx.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and oversampling rate.
package uart_pkg;

  // Receiver FSM states; PARITY is reachable only when parity is compiled in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_t;

  // Oversampling ticks per serial bit.
  localparam int OS_TICKS = 16;

endpackage

// File: rtl/baud_gen.sv
// Oversampling tick generator: free-running mod-DVSR counter that pulses
// tick for one clk at the end of every DVSR-cycle period.
module baud_gen #(
  parameter int DVSR   = 27,
  parameter int DVSR_W = 5
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [DVSR_W-1:0] CNT_LAST = DVSR_W'(DVSR - 1);

  logic [DVSR_W-1:0] cnt_reg;
  logic [DVSR_W-1:0] cnt_next;

  // Counter register, cleared by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  // Wrap to zero after the last count, otherwise advance.
  always_comb begin
    cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
  end

  assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, oversamples it with an internal baud tick,
// deframes start/data/(parity)/stop and emits one rx_done_tick per word.
// Optional parity bit and parity_err port are enabled by UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR       = 27,
  parameter int DVSR_W     = 5,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done_tick,
  output logic            frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int S_W = (SB_TICK > OS_TICKS) ? 5 : 4;
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(OS_TICKS / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OS_TICKS - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

  // Reject configurations the counters cannot represent.
  if (DVSR < 2 || (2 ** DVSR_W) < DVSR || PARITY_ODD > 1 || SB_TICK > 32)
  begin : g_bad_config
    $error("uart_rx: invalid parameter combination");
  end

  logic            tick;
  logic            rx_meta_reg;
  logic            rx_sync_reg;

  uart_state_t     state_reg, state_next;
  logic [S_W-1:0]  s_reg, s_next;
  logic [N_W-1:0]  n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic [DBIT-1:0] data_reg, data_next;
  logic            done_reg, done_next;
  logic            ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
  logic            par_reg, par_next;
  logic            perr_reg, perr_next;
`endif

  baud_gen #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // FSM state, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_reg   <= 1'b0;
      perr_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      ferr_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
      par_reg   <= par_next;
      perr_reg  <= perr_next;
`endif
    end
  end

  // Next-state logic: deframing driven by oversampling ticks.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    ferr_next  = ferr_reg;
`ifdef UART_RX_PARITY_EN
    par_next   = par_reg;
    perr_next  = perr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!rx_sync_reg) begin
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_reg == S_MID) begin
            if (!rx_sync_reg) begin
              s_next     = '0;
              n_next     = '0;
              state_next = DATA;
            end else begin
              // Line went back high before mid start bit: a glitch.
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_reg == S_LAST) begin
            b_next = {rx_sync_reg, b_reg[DBIT-1:1]};
            s_next = '0;
            n_next = n_reg + 1'b1;
            if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_reg == S_LAST) begin
            par_next   = rx_sync_reg;
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_reg == S_STOP) begin
            data_next  = b_reg;
            done_next  = 1'b1;
            ferr_next  = ~rx_sync_reg;
`ifdef UART_RX_PARITY_EN
            perr_next  = (^b_reg) ^ par_reg ^ (PARITY_ODD != 0);
`endif
            state_next = IDLE;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rx_data      = data_reg;
  assign rx_done_tick = done_reg;
  assign frame_err    = ferr_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx (DVSR=2). Each task drives one scenario and
// checks its own results; a monitor logs every rx_done_tick with its cycle.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DVSR      = 2;
  localparam int DBIT      = 8;
  localparam int SB_TICK   = 16;
  localparam int BIT_CLK   = OS_TICKS * DVSR;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME_CLK = BIT_CLK * (DBIT + 2 + PAR_BITS);
  // Start edge -> pulse: 2 sync + 1 IDLE->START + ticks, tick phase +-1 clk.
  localparam int LAT_NOM   = 3 + DVSR * (OS_TICKS / 2 + OS_TICKS * (DBIT + PAR_BITS) + SB_TICK);

  logic            clk = 1'b0;
  logic            reset;
  logic            rx;
  logic [DBIT-1:0] rx_data;
  logic            rx_done_tick;
  logic            frame_err;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;
  logic            bad_par = 1'b0;
  logic            log_perr [0:63];
`endif

  int checks = 0;
  int errors = 0;

  int unsigned     cyc = 0;
  int unsigned     done_cnt = 0;
  int unsigned     dbl_cnt = 0;
  int unsigned     frame_start_cyc = 0;
  logic            prev_done = 1'b0;
  logic [DBIT-1:0] log_data [0:63];
  logic            log_ferr [0:63];
  int unsigned     log_cyc  [0:63];

  always #5 clk = ~clk;

  uart_rx #(
    .DBIT       (DBIT),
    .SB_TICK    (SB_TICK),
    .DVSR       (DVSR),
    .DVSR_W     (5),
    .PARITY_ODD (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  // Log every completion shortly after the edge; count back-to-back highs.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rx_done_tick && prev_done) dbl_cnt++;
    if (rx_done_tick && done_cnt < 64) begin
      log_data[done_cnt] = rx_data;
      log_ferr[done_cnt] = frame_err;
      log_cyc[done_cnt]  = cyc;
`ifdef UART_RX_PARITY_EN
      log_perr[done_cnt] = parity_err;
`endif
      $display("[%0d] rx word 0x%02h ferr=%0b", cyc, rx_data, frame_err);
    end
    if (rx_done_tick) done_cnt++;
    prev_done = rx_done_tick;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One full frame; stop level held for part of the bit, then line released.
  task automatic send_frame(input logic [DBIT-1:0] d, input logic stop);
    frame_start_cyc = cyc;
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < DBIT; i++) begin
      rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ bad_par;
    repeat (BIT_CLK) @(negedge clk);
`endif
    rx = stop;
    repeat (BIT_CLK * 5 / 8) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLK - BIT_CLK * 5 / 8) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if (rx_data !== '0) begin errors++; $display("FAIL reset_rx_data got %h exp 0", rx_data); end
    checks++;
    if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", rx_done_tick); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
`ifdef UART_RX_PARITY_EN
    checks++;
    if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", parity_err); end
`endif
    reset = 1'b1;
    idle(1000);
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL idle_no_pulse got %0d exp 0", done_cnt); end
    checks++;
    if (rx_data !== '0) begin errors++; $display("FAIL idle_rx_data got %h exp 0", rx_data); end
    $display("test_reset done");
  endtask

  task automatic test_single;
    int unsigned n0 = done_cnt;
    int unsigned lat;
    send_frame(8'hA5, 1'b1);
    idle(BIT_CLK * 2);
    checks++;
    if (done_cnt != n0 + 1) begin errors++; $display("FAIL single_count got %0d exp %0d", done_cnt - n0, 1); end
    checks++;
    if (log_data[n0] !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", log_data[n0]); end
    checks++;
    if (log_ferr[n0] !== 1'b0) begin errors++; $display("FAIL single_ferr got %b exp 0", log_ferr[n0]); end
    lat = log_cyc[n0] - frame_start_cyc;
    checks++;
    if (lat < LAT_NOM - DVSR || lat > LAT_NOM + DVSR) begin
      errors++; $display("FAIL single_latency got %0d exp %0d+-%0d", lat, LAT_NOM, DVSR);
    end
    $display("test_single latency %0d", lat);
  endtask

  task automatic test_glitch;
    int unsigned n0 = done_cnt;
    rx = 1'b0;
    repeat (4 * DVSR) @(negedge clk);
    idle(BIT_CLK * 3);
    checks++;
    if (done_cnt != n0) begin errors++; $display("FAIL glitch_no_pulse got %0d exp %0d", done_cnt, n0); end
    checks++;
    if (dut.state_reg !== IDLE) begin errors++; $display("FAIL glitch_idle got %0d exp %0d", dut.state_reg, IDLE); end
    send_frame(8'h3C, 1'b1);
    idle(BIT_CLK * 2);
    checks++;
    if (done_cnt != n0 + 1) begin errors++; $display("FAIL glitch_next_count got %0d exp %0d", done_cnt - n0, 1); end
    checks++;
    if (log_data[n0] !== 8'h3C) begin errors++; $display("FAIL glitch_next_data got %h exp 3c", log_data[n0]); end
    $display("test_glitch done");
  endtask

  task automatic test_framing;
    int unsigned n0 = done_cnt;
    send_frame(8'h81, 1'b0);
    idle(BIT_CLK * 2);
    checks++;
    if (log_data[n0] !== 8'h81) begin errors++; $display("FAIL ferr_data got %h exp 81", log_data[n0]); end
    checks++;
    if (log_ferr[n0] !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b exp 1", log_ferr[n0]); end
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_hold got %b exp 1", frame_err); end
    send_frame(8'h7E, 1'b1);
    idle(BIT_CLK * 2);
    checks++;
    if (done_cnt != n0 + 2) begin errors++; $display("FAIL ferr_count got %0d exp %0d", done_cnt - n0, 2); end
    checks++;
    if (log_data[n0 + 1] !== 8'h7E) begin errors++; $display("FAIL ferr_next_data got %h exp 7e", log_data[n0 + 1]); end
    checks++;
    if (log_ferr[n0 + 1] !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b exp 0", log_ferr[n0 + 1]); end
    $display("test_framing done");
  endtask

  task automatic test_back_to_back;
    int unsigned n0 = done_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(BIT_CLK * 2);
    checks++;
    if (done_cnt != n0 + 2) begin errors++; $display("FAIL b2b_count got %0d exp %0d", done_cnt - n0, 2); end
    checks++;
    if (log_data[n0] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h exp 00", log_data[n0]); end
    checks++;
    if (log_data[n0 + 1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h exp ff", log_data[n0 + 1]); end
    checks++;
    if (log_cyc[n0 + 1] - log_cyc[n0] != FRAME_CLK) begin
      errors++; $display("FAIL b2b_spacing got %0d exp %0d", log_cyc[n0 + 1] - log_cyc[n0], FRAME_CLK);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_parity;
    int unsigned n0 = done_cnt;
    logic [DBIT-1:0] d = 8'h55;
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = d[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    idle(FRAME_CLK + BIT_CLK * 2);
    checks++;
    if (done_cnt != n0) begin errors++; $display("FAIL midreset_no_pulse got %0d exp %0d", done_cnt, n0); end
    checks++;
    if (rx_data !== '0) begin errors++; $display("FAIL midreset_rx_data got %h exp 0", rx_data); end
    send_frame(8'h12, 1'b1);
    idle(BIT_CLK * 2);
    checks++;
    if (done_cnt != n0 + 1) begin errors++; $display("FAIL after_reset_count got %0d exp %0d", done_cnt - n0, 1); end
    checks++;
    if (log_data[n0] !== 8'h12) begin errors++; $display("FAIL after_reset_data got %h exp 12", log_data[n0]); end
`ifdef UART_RX_PARITY_EN
    checks++;
    if (log_perr[n0] !== 1'b0) begin errors++; $display("FAIL good_parity got %b exp 0", log_perr[n0]); end
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1);
    bad_par = 1'b0;
    idle(BIT_CLK * 2);
    checks++;
    if (log_data[n0 + 1] !== 8'h07) begin errors++; $display("FAIL parity_data got %h exp 07", log_data[n0 + 1]); end
    checks++;
    if (log_perr[n0 + 1] !== 1'b1) begin errors++; $display("FAIL parity_err got %b exp 1", log_perr[n0 + 1]); end
`endif
    $display("test_reset_parity done");
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_parity();
    checks++;
    if (dbl_cnt != 0) begin errors++; $display("FAIL pulse_width got %0d double pulses exp 0", dbl_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
